// File: rtl/br_pred_bht.sv
// Branch history table with target buffer. Each entry holds a 2-bit saturating
// counter, a tag and a target. The table provides a combinational prediction
// to fetch and takes updates from the EX-stage resolver. It also produces the
// mispredict redirect, registered branch/correct flags and saturating stats.
module br_pred_bht #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 30 - IDX_W,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic              res_taken,
  input  logic [31:0]       res_target,
  input  logic              res_pred_taken,
  input  logic [31:0]       res_pred_target,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              branch,
  output logic              correct,
  output logic [STAT_W-1:0] stat_branch_cnt,
  output logic [STAT_W-1:0] stat_miss_cnt
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][1:0]       cnt_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;
  logic [DEPTH-1:0][31:0]      tgt_q;

  logic              branch_q, correct_q;
  logic [STAT_W-1:0] bcnt_q, mcnt_q;

  logic [IDX_W-1:0] lk_idx, rs_idx;
  logic [TAG_W-1:0] lk_tag, rs_tag;
  logic             res_fire, mispredict, rs_hit;
  logic [1:0]       cnt_d;

  // The low PC bits never affect prediction (word-aligned instructions).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], res_pc[1:0]};

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[IDX_W+2 +: TAG_W];
  assign rs_idx = res_pc[IDX_W+1:2];
  assign rs_tag = res_pc[IDX_W+2 +: TAG_W];

  // The lookup reads the registered table. A same-cycle update to the same
  // entry is therefore seen one cycle later (read-before-write).
  assign pred_taken  = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag) & cnt_q[lk_idx][1];
  assign pred_target = tgt_q[lk_idx];

  assign res_fire   = res_valid & ~stall;
  assign mispredict = res_valid & ((res_pred_taken != res_taken) |
                      (res_taken & res_pred_taken & (res_pred_target != res_target)));

  assign redirect_valid = mispredict & ~stall;
  assign redirect_pc    = res_taken ? res_target : res_pc + 32'd4;

  assign rs_hit = valid_q[rs_idx] & (tag_q[rs_idx] == rs_tag);

  // Saturating counter step for the resolving entry.
  always_comb begin
    cnt_d = cnt_q[rs_idx];
    if (res_taken) begin
      if (cnt_q[rs_idx] != 2'b11) cnt_d = cnt_q[rs_idx] + 2'd1;
    end else begin
      if (cnt_q[rs_idx] != 2'b00) cnt_d = cnt_q[rs_idx] - 2'd1;
    end
  end

  // Table update: train on a hit, allocate on a taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (res_fire) begin
      if (rs_hit) begin
        cnt_q[rs_idx] <= cnt_d;
        if (res_taken) tgt_q[rs_idx] <= res_target;
      end else if (res_taken) begin
        valid_q[rs_idx] <= 1'b1;
        tag_q[rs_idx]   <= rs_tag;
        tgt_q[rs_idx]   <= res_target;
        cnt_q[rs_idx]   <= 2'b10;
      end
    end
  end

  // Resolve flags; these hold their value through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q  <= 1'b0;
      correct_q <= 1'b1;
    end else if (!stall) begin
      branch_q  <= res_fire;
      correct_q <= ~(res_fire & mispredict);
    end
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (res_fire) begin
      if (bcnt_q != '1)              bcnt_q <= bcnt_q + 1'b1;
      if (mispredict && mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;
    end
  end

  assign branch          = branch_q;
  assign correct         = correct_q;
  assign stat_branch_cnt = bcnt_q;
  assign stat_miss_cnt   = mcnt_q;
endmodule

// File: tb/tb_br_pred_bht.sv
// Self-checking bench for br_pred_bht. It uses directed scenarios and a
// randomized phase. Both are checked against an array/integer model of the
// predictor rules.
module tb_br_pred_bht;
  logic        clk = 0, rst_n = 0, stall = 0;
  logic [31:0] if_pc = 0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid = 0, res_taken = 0, res_pred_taken = 0;
  logic [31:0] res_pc = 0, res_target = 0, res_pred_target = 0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        branch, correct;
  logic [15:0] stat_branch_cnt, stat_miss_cnt;

  int n_cmp = 0, n_err = 0;

  br_pred_bht dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .branch(branch), .correct(correct),
    .stat_branch_cnt(stat_branch_cnt), .stat_miss_cnt(stat_miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: per-index entry plus flags and counters.
  bit          m_valid [16];
  int          m_cnt   [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  bit          m_branch, m_correct;
  int          m_bcnt, m_mcnt;

  function automatic int idx_of(logic [31:0] pc);  return int'((pc >> 2) % 16); endfunction
  function automatic int unsigned tag_of(logic [31:0] pc); return pc >> 6; endfunction

  function automatic bit m_pred(logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && m_tag[i] == tag_of(pc) && m_cnt[i] >= 2;
  endfunction

  function automatic bit m_miss();
    return res_valid && ((res_pred_taken != res_taken) ||
           (res_taken && res_pred_taken && res_pred_target != res_target));
  endfunction

  function automatic logic [31:0] m_redir();
    return res_taken ? res_target : res_pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_branch = 0; m_correct = 1; m_bcnt = 0; m_mcnt = 0;
  endtask

  // Apply one rising edge to the model using the current inputs.
  task automatic model_edge();
    bit fire, miss;
    int i;
    if (stall) return;
    fire = res_valid;
    miss = m_miss();
    m_branch  = fire;
    m_correct = !(fire && miss);
    if (!fire) return;
    if (m_bcnt < 65535) m_bcnt++;
    if (miss && m_mcnt < 65535) m_mcnt++;
    i = idx_of(res_pc);
    if (m_valid[i] && m_tag[i] == tag_of(res_pc)) begin
      m_cnt[i] = res_taken ? (m_cnt[i] == 3 ? 3 : m_cnt[i] + 1)
                           : (m_cnt[i] == 0 ? 0 : m_cnt[i] - 1);
      if (res_taken) m_tgt[i] = res_target;
    end else if (res_taken) begin
      m_valid[i] = 1; m_tag[i] = tag_of(res_pc); m_tgt[i] = res_target; m_cnt[i] = 2;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_res(bit v, logic [31:0] pc, bit t, logic [31:0] tg, bit pt, logic [31:0] ptg);
    res_valid = v; res_pc = pc; res_taken = t; res_target = tg;
    res_pred_taken = pt; res_pred_target = ptg;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset(); if_pc = 32'h40;
    #12 rst_n = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred got %b want 0", pred_taken); end
      n_cmp++; if (branch !== 1'b0 || correct !== 1'b1) begin n_err++; $display("FAIL reset_flags got br=%b co=%b want 0/1", branch, correct); end
      n_cmp++; if (stat_branch_cnt !== 16'd0 || stat_miss_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branch_cnt, stat_miss_cnt); end
      cyc();
    end
  endtask

  task automatic test_alloc();
    set_res(1, 32'h40, 1, 32'h20, 0, 0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h20) begin n_err++; $display("FAIL alloc_redirect got v=%b pc=%h want 1/00000020", redirect_valid, redirect_pc); end
    cyc();
    set_res(0, 0, 0, 0, 0, 0);
    if_pc = 32'h40; #1;
    n_cmp++; if (branch !== 1'b1 || correct !== 1'b0) begin n_err++; $display("FAIL alloc_flags got br=%b co=%b want 1/0", branch, correct); end
    n_cmp++; if (stat_miss_cnt !== 16'(m_mcnt) || m_mcnt != 1) begin n_err++; $display("FAIL alloc_miss got %0d want 1", stat_miss_cnt); end
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h20) begin n_err++; $display("FAIL alloc_pred got %b/%h want 1/00000020", pred_taken, pred_target); end
  endtask

  task automatic test_train_down();
    bit exp_p [3] = '{1, 0, 0};
    for (int k = 0; k < 3; k++) begin
      if_pc = 32'h40;
      set_res(1, 32'h40, 0, 32'h20, m_pred(32'h40), 32'h20);
      n_cmp++; if (pred_taken !== exp_p[k]) begin n_err++; $display("FAIL train_pred[%0d] got %b want %b", k, pred_taken, exp_p[k]); end
      if (k == 0) begin
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin n_err++; $display("FAIL train_redirect got %b/%h want 1/00000044", redirect_valid, redirect_pc); end
      end else begin
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL train_noredir[%0d] got %b want 0", k, redirect_valid); end
      end
      res_pred_taken = pred_taken;
      cyc();
    end
    set_res(0, 0, 0, 0, 0, 0);
    n_cmp++; if (stat_branch_cnt !== 16'd4 || m_cnt[0] != 0) begin n_err++; $display("FAIL train_bcnt got %0d want 4 (model cnt %0d)", stat_branch_cnt, m_cnt[0]); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL train_final_pred got %b want 0", pred_taken); end
  endtask

  task automatic test_alias();
    set_res(1, 32'h80, 1, 32'h100, 0, 0);
    cyc();
    set_res(0, 0, 0, 0, 0, 0);
    if_pc = 32'h40; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_old got %b want 0", pred_taken); end
    if_pc = 32'h80; #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin n_err++; $display("FAIL alias_new got %b/%h want 1/00000100", pred_taken, pred_target); end
  endtask

  task automatic test_stall();
    logic       b0, c0;
    logic [15:0] bc0, mc0;
    b0 = branch; c0 = correct; bc0 = stat_branch_cnt; mc0 = stat_miss_cnt;
    if_pc = 32'h80;
    stall = 1;
    set_res(1, 32'h80, 0, 0, 1, 32'h100);
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL stall_redir got %b want 0", redirect_valid); end
    cyc(); cyc();
    n_cmp++; if (branch !== b0 || correct !== c0) begin n_err++; $display("FAIL stall_flags got %b/%b want %b/%b", branch, correct, b0, c0); end
    n_cmp++; if (stat_branch_cnt !== bc0 || stat_miss_cnt !== mc0) begin n_err++; $display("FAIL stall_stats got %0d/%0d want %0d/%0d", stat_branch_cnt, stat_miss_cnt, bc0, mc0); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL stall_table got %b want 1", pred_taken); end
    stall = 0; #1;
    cyc();
    set_res(0, 0, 0, 0, 0, 0);
    n_cmp++; if (stat_branch_cnt !== bc0 + 16'd1 || stat_miss_cnt !== mc0 + 16'd1) begin n_err++; $display("FAIL unstall_stats got %0d/%0d want %0d/%0d", stat_branch_cnt, stat_miss_cnt, bc0 + 16'd1, mc0 + 16'd1); end
    n_cmp++; if (branch !== 1'b1 || correct !== 1'b0 || pred_taken !== 1'b0 || m_cnt[0] != 1) begin n_err++; $display("FAIL unstall_apply got br=%b co=%b pred=%b want 1/0/0", branch, correct, pred_taken); end
  endtask

  task automatic test_rbw();
    // Entry 0 now holds cnt 01; a taken hit raises it to 10.
    if_pc = 32'h80;
    set_res(1, 32'h80, 1, 32'h100, 0, 0);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rbw_old got %b want 0", pred_taken); end
    cyc();
    set_res(0, 0, 0, 0, 0, 0);
    n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin n_err++; $display("FAIL rbw_new got %b/%h want 1/00000100", pred_taken, pred_target); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      logic [31:0] pc;
      pc = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      if_pc = ($urandom_range(0, 1) != 0) ? pc : {26'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      stall = ($urandom_range(0, 4) == 0);
      set_res($urandom_range(0, 2) != 0, pc, $urandom_range(0, 1),
              {24'h0, 6'($urandom_range(0, 3)), 2'b00},
              ($urandom_range(0, 3) == 0) ? bit'($urandom_range(0, 1)) : m_pred(pc),
              ($urandom_range(0, 3) == 0) ? {24'h0, 6'($urandom_range(0, 3)), 2'b00} : m_tgt[idx_of(pc)]);
      n_cmp++; if (pred_taken !== m_pred(if_pc)) begin n_err++; $display("FAIL rnd_pred c=%0d got %b want %b", c, pred_taken, m_pred(if_pc)); end
      if (m_pred(if_pc)) begin
        n_cmp++; if (pred_target !== m_tgt[idx_of(if_pc)]) begin n_err++; $display("FAIL rnd_tgt c=%0d got %h want %h", c, pred_target, m_tgt[idx_of(if_pc)]); end
      end
      n_cmp++; if (redirect_valid !== (m_miss() && !stall)) begin n_err++; $display("FAIL rnd_redir c=%0d got %b want %b", c, redirect_valid, m_miss() && !stall); end
      n_cmp++; if (redirect_pc !== m_redir()) begin n_err++; $display("FAIL rnd_redir_pc c=%0d got %h want %h", c, redirect_pc, m_redir()); end
      cyc();
      n_cmp++; if (branch !== m_branch || correct !== m_correct) begin n_err++; $display("FAIL rnd_flags c=%0d got %b/%b want %b/%b", c, branch, correct, m_branch, m_correct); end
      n_cmp++; if (stat_branch_cnt !== 16'(m_bcnt) || stat_miss_cnt !== 16'(m_mcnt)) begin n_err++; $display("FAIL rnd_stats c=%0d got %0d/%0d want %0d/%0d", c, stat_branch_cnt, stat_miss_cnt, m_bcnt, m_mcnt); end
    end
    stall = 0;
    set_res(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    if_pc = 32'h80;
    set_res(1, 32'h80, 1, 32'h100, 0, 0);
    cyc();
    set_res(1, 32'h80, 1, 32'h200, 0, 0);
    #2 rst_n = 0; model_reset(); #1;
    n_cmp++; if (pred_taken !== 1'b0 || branch !== 1'b0 || correct !== 1'b1 || stat_branch_cnt !== 16'd0) begin n_err++; $display("FAIL async_reset got pred=%b br=%b co=%b bc=%0d want 0/0/1/0", pred_taken, branch, correct, stat_branch_cnt); end
    set_res(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1;
    cyc();
    n_cmp++; if (pred_taken !== 1'b0 || stat_miss_cnt !== 16'd0) begin n_err++; $display("FAIL post_reset got pred=%b mc=%0d want 0/0", pred_taken, stat_miss_cnt); end
  endtask

  task automatic test_stat_sat();
    int guard = 0;
    set_res(1, 32'h40, 1, 32'h20, 0, 0);
    while (m_mcnt < 65535 + 3 && guard < 65540) begin
      cyc(); guard++;
      if (m_mcnt == 65535) m_mcnt = 65535 + 1;   // mark saturation reached, then run 2 more
      else if (m_mcnt > 65535) m_mcnt++;
    end
    m_mcnt = 65535;
    n_cmp++; if (guard >= 65540) begin n_err++; $display("FAIL sat_guard cycles=%0d", guard); end
    n_cmp++; if (stat_miss_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_miss got %h want ffff", stat_miss_cnt); end
    n_cmp++; if (stat_branch_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_branch got %h want ffff", stat_branch_cnt); end
    set_res(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_train_down();
    test_alias();
    test_stall();
    test_rbw();
    test_random();
    test_async_reset();
    test_stat_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/br_pred_bht.md
Name: br_pred_bht

Overview:
- Dynamic branch predictor inside CHIP, between the IF stage (PC lookup) and the EX-stage branch resolver.
- Direct-mapped table of 2-bit saturating counters with tag and target storage (BHT+BTB).
- Gives the IF stage a taken/target prediction and the pipeline a same-cycle redirect on mispredict.
- Drives the registered `branch`/`correct` pair the testbed counts every cycle, plus saturating statistics counters.

Parameters:
- IDX_W, 4: index bits; table depth 2**IDX_W, index = pc[IDX_W+1:2].
- TAG_W, 30-IDX_W: tag = pc[31:IDX_W+2].
- STAT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  pipeline stall; when 1, suppresses all state updates.
- if_pc  input  32  fetch PC to predict.
- pred_taken  output  1  combinational: entry valid, tag hit and counter[1].
- pred_target  output  32  combinational: stored target of the indexed entry (don't-care when pred_taken=0).
- res_valid  input  1  a branch resolves in EX this cycle.
- res_pc  input  32  PC of the resolving branch.
- res_taken  input  1  actual direction.
- res_target  input  32  actual taken target.
- res_pred_taken  input  1  prediction carried down the pipe for this branch.
- res_pred_target  input  32  predicted target carried down the pipe.
- redirect_valid  output  1  combinational mispredict flush.
- redirect_pc  output  32  res_taken ? res_target : res_pc+4.
- branch  output  1  registered: a branch resolved last cycle.
- correct  output  1  registered: 0 only in the cycle after a mispredicted resolve.
- stat_branch_cnt  output  STAT_W  resolved-branch count.
- stat_miss_cnt  output  STAT_W  mispredict count.

Behaviour:
- Reset (async, rst_n=0):
  - All entries: valid=0, cnt=2'b01, tag and target=0.
  - Outputs: branch=0, correct=1, both stat counters 0.
  - An update in flight is discarded; prediction reads return pred_taken=0 immediately.
- Definitions:
  - res_fire = res_valid & ~stall.
  - mispredict = res_valid & ((res_pred_taken != res_taken) | (res_taken & res_pred_taken & (res_pred_target != res_target))).
- Redirect:
  - redirect_valid = mispredict, gated by ~stall; same-cycle combinational.
  - redirect_pc = res_taken ? res_target : res_pc+4, 32-bit with wrap at 2**32.
- Registered flags (updated on every non-stalled edge; hold while stall=1):
  - branch <= res_fire.
  - correct <= ~(res_fire & mispredict).
  - correct stays 1 on cycles with no branch.
- Table update on res_fire, at index/tag taken from res_pc:
  - Hit (valid and tag match): cnt saturating +1 if taken (max 2'b11), else −1 (min 2'b00). If taken, target <= res_target.
  - Miss and taken: allocate. valid=1, tag, target=res_target, cnt=2'b10 (overwrites any aliased entry).
  - Miss and not taken: no change.
- Read/write ordering: lookup and update in the same cycle on the same index return the pre-update entry (read-before-write). The new value is visible the next cycle.
- Statistics:
  - stat_branch_cnt += 1 per res_fire.
  - stat_miss_cnt += 1 per res_fire & mispredict.
  - Both saturate at all-ones; no wrap.
- No other state machine: the table is the only state besides the flags and counters.

Test Plan:
- Reset released, if_pc=0x0000_0040 → pred_taken=0; branch=0, correct=1 held for 5 cycles.
- Resolve res_pc=0x40, taken, target=0x20, pred_taken=0 → redirect_valid=1 with redirect_pc=0x20 that cycle; next cycle branch=1, correct=0, miss_cnt=1. Then if_pc=0x40 → pred_taken=1, pred_target=0x20.
- Same branch resolved not-taken 3× with pred_taken tracking the table → cnt 10→01→00→00, pred_taken=0 after the first. redirect_pc=0x44 on the mispredict. branch_cnt=4.
- Alias: res_pc=0x80 (same index, IDX_W=4, different tag) taken to 0x100 → entry replaced. if_pc=0x40 → pred_taken=0; if_pc=0x80 → pred_target=0x100.
- Stall=1 with res_valid=1 → no table change, branch and correct hold, counters unchanged. Repeat with stall=0 → update applies once.
- Same-cycle lookup and update of index 0 → prediction shows old cnt; next cycle shows new. Force stat_miss_cnt to 0xFFFF and mispredict → stays 0xFFFF.
